// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the L1 instruction memory one request at a time,
// pairs each returned word with its PC and hands entries to decode through a small FIFO.
module fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pcin_if,
    output logic        pcwrite,
    input  logic [31:0] inst_if,
    input  logic        inst_access_fault,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_fault
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    state_t             state;
    state_t             state_next;
    logic [63:0]        pc;
    logic               inflight;
    logic [63:0]        inflight_pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    entry_t             fifo_mem [FIFO_DEPTH];

    entry_t             head;
    entry_t             push_entry;
    logic               head_valid;
    logic               pop;
    logic               push;
    logic               room;
    logic [CNT_W:0]     occupancy;
    logic               unused_pc_lo;

    // The low two bits of a redirect target are architecturally ignored.
    assign unused_pc_lo = ^redirect_pc[1:0];

    assign head       = fifo_mem[rd_ptr];
    assign head_valid = (count != '0);
    assign pcin_if    = pc;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        id_valid   = head_valid & ~redirect_valid;
        pop        = id_valid & id_ready;
        push       = inflight & ~redirect_valid;
        occupancy  = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
        room       = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
        // rstn gates the enable so memory sees no request while reset is asserted.
        pcwrite    = rstn & (state == RUN) & room & ~redirect_valid
                   & ~(inflight & inst_access_fault);

        push_entry.pc    = inflight_pc;
        push_entry.inst  = inst_access_fault ? 32'h0 : inst_if;
        push_entry.fault = inst_access_fault;

        if (redirect_valid) begin
            state_next = RUN;
        end else if (push && inst_access_fault) begin
            state_next = FAULT;
        end

        id_pc    = head_valid ? head.pc    : 64'h0;
        id_inst  = head_valid ? head.inst  : 32'h0;
        id_fault = head_valid ? head.fault : 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 64'h0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state    <= state_next;
            inflight <= pcwrite;
            if (pcwrite) begin
                inflight_pc <= pc;
            end

            if (redirect_valid) begin
                pc <= {redirect_pc[63:2], 2'b00};
            end else if (pcwrite) begin
                pc <= pc + 64'd4;
            end

            // A redirect flushes the queue; returning data that cycle is dropped via push.
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // NOTE: queue storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural memory, a scoreboard queue of expected
// PCs rebuilt on every redirect/reset, directed boundary scenarios and a randomized phase.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC  = 64'h0;
    localparam logic [63:0] FAULT_LIM = 64'd1000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pcin_if;
    logic        pcwrite;
    logic [31:0] inst_if;
    logic        inst_access_fault;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;

    int n_checks = 0;
    int n_errors = 0;
    int pops     = 0;

    logic [63:0] exp_q[$];

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .pcin_if           (pcin_if),
        .pcwrite           (pcwrite),
        .inst_if           (inst_if),
        .inst_access_fault (inst_access_fault),
        .id_valid          (id_valid),
        .id_ready          (id_ready),
        .id_pc             (id_pc),
        .id_inst           (id_inst),
        .id_fault          (id_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Memory: samples address every edge; fault flag depends only on the sampled address.
    logic [63:0] mem_addr = 64'h0;
    logic        mem_en   = 1'b0;
    logic [31:0] junk     = 32'h0;
    always @(posedge clk) begin
        mem_addr <= pcin_if;
        mem_en   <= pcwrite;
        junk     <= $urandom;
    end
    assign inst_if           = mem_en ? mem_word(mem_addr) : junk;
    assign inst_access_fault = (mem_addr >= FAULT_LIM);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: after a (re)start the stream is start, start+4, ... ending with the first faulting PC.
    task automatic refill(input logic [63:0] start);
        logic [63:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(a);
            if (a >= FAULT_LIM) break;
            a = a + 64'd4;
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rstn) begin
            refill(RESET_PC);
        end else begin
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: got entry pc=%0h, expected none", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", id_pc, e);
                    check("sb_fault", {63'h0, id_fault}, {63'h0, (e >= FAULT_LIM)});
                    check("sb_inst", {32'h0, id_inst}, {32'h0, (e >= FAULT_LIM) ? 32'h0 : mem_word(e)});
                    pops++;
                end
            end
            if (redirect_valid) begin
                check("redirect_blocks_valid", {63'h0, id_valid}, 64'h0);
                refill({redirect_pc[63:2], 2'b00});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [63:0] target);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        bit found;
        int bad;
        int rand_pops;
        logic [63:0] tgt;

        rstn           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_ready       = 1'b1;
        repeat (3) @(posedge clk);

        @(negedge clk);
        check("rst_pcwrite",  {63'h0, pcwrite},  64'h0);
        check("rst_id_valid", {63'h0, id_valid}, 64'h0);
        check("rst_id_pc",    id_pc,             64'h0);
        check("rst_id_inst",  {32'h0, id_inst},  64'h0);
        check("rst_id_fault", {63'h0, id_fault}, 64'h0);

        // Release: issue on first cycle, first entry two cycles later, then one per cycle.
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("c0_pcwrite",  {63'h0, pcwrite},  64'h1);
        check("c0_pcin",     pcin_if,           RESET_PC);
        check("c0_id_valid", {63'h0, id_valid}, 64'h0);
        @(negedge clk);
        check("c1_pcin",     pcin_if,           RESET_PC + 64'd4);
        check("c1_id_valid", {63'h0, id_valid}, 64'h0);
        @(negedge clk);
        check("c2_id_valid", {63'h0, id_valid}, 64'h1);
        check("c2_id_pc",    id_pc,             RESET_PC);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("stream_valid", {63'h0, id_valid}, 64'h1);
            check("stream_pc",    id_pc,             RESET_PC + 64'(4 * k));
        end

        // Backpressure: FIFO fills, fetch stops, head holds.
        tick();
        id_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_pcwrite",  {63'h0, pcwrite},  64'h0);
        check("bp_id_valid", {63'h0, id_valid}, 64'h1);
        check("bp_head_pc",  id_pc,             exp_q[0]);

        // Redirect while full: flush, aligned target issued next cycle.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h43;
        @(negedge clk);
        check("rd_id_valid", {63'h0, id_valid}, 64'h0);
        check("rd_pcwrite",  {63'h0, pcwrite},  64'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd1_pcwrite",  {63'h0, pcwrite},  64'h1);
        check("rd1_pcin",     pcin_if,           64'h40);
        check("rd1_id_valid", {63'h0, id_valid}, 64'h0);
        tick();
        id_ready = 1'b1;
        @(negedge clk);
        check("rd2_id_valid", {63'h0, id_valid}, 64'h0);
        @(negedge clk);
        check("rd3_id_valid", {63'h0, id_valid}, 64'h1);
        check("rd3_id_pc",    id_pc,             64'h40);

        // Sequential fetch into the fault region.
        redirect(64'd960);
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (id_valid && id_fault) begin
                found = 1'b1;
                check("fault_pc",   id_pc,            64'd1000);
                check("fault_inst", {32'h0, id_inst}, 64'h0);
                break;
            end
        end
        check("fault_seen", {63'h0, found}, 64'h1);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (pcwrite) bad++;
        end
        check("fault_hold_pcwrite", 64'(bad), 64'h0);
        check("fault_drained",      {63'h0, id_valid}, 64'h0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h10;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("resume_pcwrite", {63'h0, pcwrite}, 64'h1);
        check("resume_pcin",    pcin_if,          64'h10);

        // Redirect coinciding with a faulting return.
        redirect(64'd992);
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pcwrite && pcin_if == 64'd1000) begin
                found = 1'b1;
                break;
            end
        end
        check("rf_issue_1000", {63'h0, found}, 64'h1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        @(negedge clk);
        check("rf_pcwrite", {63'h0, pcwrite}, 64'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rf_resume_pcwrite", {63'h0, pcwrite}, 64'h1);
        check("rf_resume_pcin",    pcin_if,          64'h200);
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (id_valid && id_fault) bad++;
        end
        check("rf_no_fault_entry", 64'(bad), 64'h0);

        // Asynchronous reset mid-stream with a non-empty FIFO.
        tick();
        id_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("mr_nonempty", {63'h0, id_valid}, 64'h1);
        tick();
        rstn = 1'b0;
        #1;
        check("mr_pcwrite",  {63'h0, pcwrite},  64'h0);
        check("mr_id_valid", {63'h0, id_valid}, 64'h0);
        check("mr_id_pc",    id_pc,             64'h0);
        check("mr_id_inst",  {32'h0, id_inst},  64'h0);
        check("mr_id_fault", {63'h0, id_fault}, 64'h0);
        repeat (2) tick();
        rstn     = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        check("mr_restart_pcwrite", {63'h0, pcwrite}, 64'h1);
        check("mr_restart_pcin",    pcin_if,          RESET_PC);

        // Randomized traffic: backpressure and redirects to assorted targets.
        rand_pops = pops;
        for (int i = 0; i < 3000; i++) begin
            tick();
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tgt = 64'($urandom_range(0, 400));
                    1:       tgt = 64'($urandom_range(900, 1010));
                    2:       tgt = 64'($urandom_range(0, 2000));
                    default: tgt = {$urandom, $urandom};
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        repeat (10) tick();
        check("rand_progress", {63'h0, ((pops - rand_pops) > 300)}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
